// File: rtl/trng_pkg.sv
// Shared types for the TRNG request controller: FSM states, the external
// state_code mapping and default sizing.
package trng_pkg;

    localparam int DEF_WARMUP_CYCLES  = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int DEF_VEC_W          = 8;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        WARMUP,
        COLLECT,
        PRESENT,
        ERROR
    } trng_state_e;

    // Two-bit code shown on the debug pins; idle/present and flush/warmup share codes.
    function automatic logic [1:0] state_code_of(input trng_state_e s);
        logic [1:0] code;
        code = 2'b00;
        case (s)
            IDLE, PRESENT:  code = 2'b00;
            FLUSH, WARMUP:  code = 2'b01;
            COLLECT:        code = 2'b10;
            ERROR:          code = 2'b11;
            default:        code = 2'b00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/trng_cycle_counter.sv
// Loadable down-counter shared by the warm-up window and the collect timeout.
module trng_cycle_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // Saturates at zero; the controller always reloads before relying on it again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/trng_request_controller.sv
// Sequences the TRNG entropy path: source selection, debiaser/BIST flush,
// warm-up discard, 8-bit assembly and the consumer handshake.
module trng_request_controller
    import trng_pkg::*;
#(
    parameter int WARMUP_CYCLES  = DEF_WARMUP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int VEC_W          = DEF_VEC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       src_sel,
    input  logic             req,
    input  logic             req_ss,
    input  logic             bist_en,
    input  logic             bist_fail,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             ack,
    output logic [1:0]       src_sel_q,
    output logic             flush,
    output logic [VEC_W-1:0] vector,
    output logic             vector_valid,
    output logic             busy,
    output logic             error,
    output logic [1:0]       state_code
);

    localparam int CNT_MAX = (WARMUP_CYCLES > TIMEOUT_CYCLES) ? WARMUP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int BC_W    = $clog2(VEC_W + 1);

    localparam logic [CNT_W-1:0] WARMUP_LD  = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BC_W-1:0]  LAST_BIT   = BC_W'(VEC_W - 1);

    trng_state_e      state, state_n;
    logic             req_d;
    logic             warmed, warmed_n;
    logic [1:0]       src_sel_q_n;
    logic [VEC_W-1:0] shift_q, shift_n, shifted;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_n;
    logic [VEC_W-1:0] vector_n;
    logic             start, src_changed;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;

    trng_cycle_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign start       = req_ss ? (req & ~req_d) : req;
    assign src_changed = (src_sel != src_sel_q);
    assign shifted     = {shift_q[VEC_W-2:0], bit_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_d     <= 1'b0;
            warmed    <= 1'b0;
            src_sel_q <= 2'b00;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            vector    <= '0;
        end else begin
            state     <= state_n;
            req_d     <= req;
            warmed    <= warmed_n;
            src_sel_q <= src_sel_q_n;
            shift_q   <= shift_n;
            bit_cnt_q <= bit_cnt_n;
            vector    <= vector_n;
        end
    end

    // Handshake: vector_valid is high exactly while in PRESENT, vector is held
    // stable for that whole time, and an ack sampled high on an edge in PRESENT
    // consumes it so vector_valid is low from that edge on.
    always_comb begin
        state_n      = state;
        warmed_n     = warmed;
        src_sel_q_n  = src_sel_q;
        shift_n      = shift_q;
        bit_cnt_n    = bit_cnt_q;
        vector_n     = vector;
        cnt_load     = 1'b0;
        cnt_load_val = TIMEOUT_LD;
        cnt_dec      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (src_changed || !warmed) begin
                        state_n     = FLUSH;
                        src_sel_q_n = src_sel;
                    end else begin
                        state_n  = COLLECT;
                        cnt_load = 1'b1;
                    end
                end
            end

            FLUSH: begin
                cnt_load     = 1'b1;
                cnt_load_val = WARMUP_LD;
                bit_cnt_n    = '0;
                shift_n      = '0;
                state_n      = WARMUP;
            end

            WARMUP: begin
                if (cnt_zero) begin
                    warmed_n = 1'b1;
                    cnt_load = 1'b1;
                    state_n  = COLLECT;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            COLLECT: begin
                // A source change wins over a bit in the same cycle; the partial
                // vector is cleared in FLUSH.
                if (src_changed) begin
                    state_n     = FLUSH;
                    src_sel_q_n = src_sel;
                end else if (bit_valid) begin
                    cnt_load = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        vector_n  = shifted;
                        shift_n   = '0;
                        bit_cnt_n = '0;
                        if (bist_en && bist_fail) begin
                            state_n  = ERROR;
                            warmed_n = 1'b0;
                        end else begin
                            state_n = PRESENT;
                        end
                    end else begin
                        shift_n   = shifted;
                        bit_cnt_n = bit_cnt_q + 1'b1;
                    end
                end else if (cnt_zero) begin
                    state_n  = ERROR;
                    warmed_n = 1'b0;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            PRESENT: begin
                if (ack) begin
                    if (!req_ss && req) begin
                        if (src_changed) begin
                            state_n     = FLUSH;
                            src_sel_q_n = src_sel;
                        end else begin
                            state_n  = COLLECT;
                            cnt_load = 1'b1;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
            end

            ERROR: begin
                if (!req) state_n = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end

    assign flush        = (state == FLUSH);
    assign vector_valid = (state == PRESENT);
    assign busy         = (state != IDLE);
    assign error        = (state == ERROR);
    assign state_code   = state_code_of(state);

endmodule

// File: tb/tb_trng_request_controller.sv
// Directed bench for trng_request_controller: request flows, continuous mode,
// source change, starvation, BIST gating and asynchronous reset.
module tb_trng_request_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] src_sel;
    logic       req, req_ss, bist_en, bist_fail, bit_in, bit_valid, ack;
    logic [1:0] src_sel_q;
    logic       flush;
    logic [7:0] vector;
    logic       vector_valid, busy, error;
    logic [1:0] state_code;

    int checks   = 0;
    int failures = 0;
    int flush_cnt = 0;
    int flush_before;

    trng_request_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_sel      (src_sel),
        .req          (req),
        .req_ss       (req_ss),
        .bist_en      (bist_en),
        .bist_fail    (bist_fail),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .ack          (ack),
        .src_sel_q    (src_sel_q),
        .flush        (flush),
        .vector       (vector),
        .vector_valid (vector_valid),
        .busy         (busy),
        .error        (error),
        .state_code   (state_code)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    always @(negedge clk) if (flush === 1'b1) flush_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        if ($urandom_range(0, 1) == 1) tick(1);
        bit_in    = b;
        bit_valid = 1'b1;
        tick(1);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input logic fail_last);
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        chk("no_valid_before_8th", {31'd0, vector_valid}, 32'd0);
        bist_fail = fail_last;
        send_bit(v[0]);
        bist_fail = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; src_sel = 2'd0; req = 0; req_ss = 1; bist_en = 0;
        bist_fail = 0; bit_in = 0; bit_valid = 0; ack = 0;
        #12;
        chk("rst_outputs", {vector, src_sel_q, flush, vector_valid, busy, error, state_code},
            32'd0);
        #5 rst_n = 1'b1;
        tick(1);

        // Reset then first single-shot request on source 2
        src_sel = 2'd2; req = 1'b1;
        tick(1);
        chk("s1_flush", {31'd0, flush}, 32'd1);
        chk("s1_src_q", {30'd0, src_sel_q}, 32'd2);
        chk("s1_code_flush", {30'd0, state_code}, 32'd1);
        req = 1'b0;
        tick(1);
        chk("s1_flush_one_cycle", {31'd0, flush}, 32'd0);
        bit_valid = 1'b1; bit_in = 1'b1;
        tick(14);
        bit_valid = 1'b0; bit_in = 1'b0;
        tick(1);
        chk("s1_warmup_16th", {30'd0, state_code}, 32'd1);
        tick(1);
        chk("s1_collect", {30'd0, state_code}, 32'd2);
        send_byte(8'hB2, 1'b0);
        chk("s1_vector", {24'd0, vector}, 32'hB2);
        chk("s1_valid", {31'd0, vector_valid}, 32'd1);
        src_sel = 2'd1;
        tick(3);
        chk("s1_held_valid", {31'd0, vector_valid}, 32'd1);
        chk("s1_src_deferred", {30'd0, src_sel_q}, 32'd2);
        src_sel = 2'd2;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("s1_ack_idle", {30'd0, busy, vector_valid}, 32'd0);

        // Continuous mode, three back-to-back vectors, no flush
        flush_before = flush_cnt;
        req_ss = 1'b0; req = 1'b1;
        tick(1);
        chk("s2_direct_collect", {30'd0, state_code}, 32'd2);
        send_byte(8'h5A, 1'b0);
        chk("s2_v1", {23'd0, vector_valid, vector}, 32'h15A);
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("s2_recollect1", {29'd0, vector_valid, state_code}, 32'd2);
        send_byte(8'hC3, 1'b0);
        chk("s2_v2", {23'd0, vector_valid, vector}, 32'h1C3);
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("s2_recollect2", {29'd0, vector_valid, state_code}, 32'd2);
        send_byte(8'h0F, 1'b0);
        chk("s2_v3", {23'd0, vector_valid, vector}, 32'h10F);
        req = 1'b0;
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("s2_idle", {31'd0, busy}, 32'd0);
        chk("s2_no_flush", flush_cnt - flush_before, 32'd0);

        // Source change 1 -> 3 mid-COLLECT
        req_ss = 1'b1; src_sel = 2'd1; req = 1'b1;
        tick(1);
        req = 1'b0;
        chk("s3_flush1", {29'd0, flush, src_sel_q}, 32'h5);
        tick(17);
        chk("s3_collect1", {30'd0, state_code}, 32'd2);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        src_sel = 2'd3;
        tick(1);
        chk("s3_flush3", {29'd0, flush, src_sel_q}, 32'h7);
        tick(16);
        chk("s3_full_warmup", {30'd0, state_code}, 32'd1);
        tick(1);
        chk("s3_collect3", {30'd0, state_code}, 32'd2);
        send_byte(8'h96, 1'b0);
        chk("s3_vector", {23'd0, vector_valid, vector}, 32'h196);
        ack = 1'b1; tick(1); ack = 1'b0;

        // Starvation timeout
        req = 1'b1;
        tick(1);
        chk("s4_collect", {29'd0, flush, state_code}, 32'd2);
        tick(1023);
        chk("s4_before_timeout", {30'd0, state_code}, 32'd2);
        tick(1);
        chk("s4_error", {28'd0, error, vector_valid, state_code}, 32'hB);
        tick(5);
        chk("s4_error_held", {31'd0, error}, 32'd1);
        req = 1'b0;
        tick(1);
        chk("s4_idle", {29'd0, error, state_code}, 32'd0);
        req = 1'b1;
        tick(1);
        req = 1'b0;
        chk("s4_reflush", {31'd0, flush}, 32'd1);
        tick(17);

        // BIST gate: fail at the 8th bit with bist_en=1, then bist_en=0
        bist_en = 1'b1;
        send_byte(8'hE7, 1'b1);
        chk("s5_bist_error", {29'd0, vector_valid, state_code}, 32'd3);
        tick(1);
        chk("s5_error_idle", {31'd0, busy}, 32'd0);
        bist_en = 1'b0;
        req = 1'b1;
        tick(1);
        req = 1'b0;
        chk("s5_reflush", {31'd0, flush}, 32'd1);
        tick(17);
        send_byte(8'hE7, 1'b1);
        chk("s5_present", {23'd0, vector_valid, vector}, 32'h1E7);
        ack = 1'b1; tick(1); ack = 1'b0;

        // Async reset while presenting
        req = 1'b1;
        tick(1);
        req = 1'b0;
        send_byte(8'h3C, 1'b0);
        chk("s6_present", {23'd0, vector_valid, vector}, 32'h13C);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_async_rst", {vector, src_sel_q, flush, vector_valid, busy, error, state_code},
            32'd0);
        #3 rst_n = 1'b1;
        tick(1);
        src_sel = 2'd0; req = 1'b1;
        tick(1);
        req = 1'b0;
        chk("s6_flush_after_rst", {29'd0, flush, src_sel_q}, 32'h4);
        tick(17);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        bit_valid = 1'b1; bit_in = 1'b1; src_sel = 2'd1;
        tick(1);
        bit_valid = 1'b0; bit_in = 1'b0;
        chk("s6_simul_flush", {29'd0, flush, src_sel_q}, 32'h5);
        tick(17);
        send_byte(8'hA5, 1'b0);
        chk("s6_vector", {23'd0, vector_valid, vector}, 32'h1A5);
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("s6_idle", {31'd0, busy}, 32'd0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
